// File: rtl/instruction_loader_if.sv
// Byte-stream handshake and instruction-memory write port between the boot-load
// host and the instruction loader.
interface instruction_loader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int BUS_WIDTH  = 32
);
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [BUS_WIDTH-1:0]  data_in;
  logic                  wr_en;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, write_addr, data_in, wr_en
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, write_addr, data_in, wr_en
  );
endinterface

// File: rtl/instruction_loader.sv
// Boot loader: takes a 16-bit big-endian word count followed by big-endian 32-bit
// words over a byte handshake and writes them to instruction memory from address 0.
module instruction_loader #(
  parameter int CAPACITY   = 512,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(CAPACITY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  instruction_loader_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, FLUSH} state_t;

  localparam logic [16:0] CAP = 17'(CAPACITY);

  state_t      state, state_n;
  logic [15:0] length;
  logic [15:0] len_rx;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        byte_ready;
  logic        accept;
  logic        last_word;
  logic        start_ok;

  assign bus.byte_ready = byte_ready;
  assign accept         = bus.byte_valid & byte_ready;
  assign len_rx         = {length[15:8], bus.byte_in};
  assign last_word      = (17'(word_count) + 17'd1) == {1'b0, length};
  // done is high during the first IDLE cycle; a start landing there is dropped
  assign start_ok       = start & ~done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    unique case (state)
      IDLE:   if (start_ok) state_n = LEN_HI;
      LEN_HI: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) state_n = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          if (len_rx == 16'd0 || {1'b0, len_rx} > CAP) state_n = FLUSH;
          else                                          state_n = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (bus.byte_valid && byte_cnt == 2'd3 && last_word) state_n = FLUSH;
      end
      FLUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length         <= '0;
      byte_cnt       <= '0;
      shift          <= '0;
      bus.write_addr <= '0;
      bus.data_in    <= '0;
      bus.wr_en      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      word_count     <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: if (start_ok) begin
          busy       <= 1'b1;
          error      <= 1'b0;
          word_count <= '0;
        end
        LEN_HI: if (accept) length[15:8] <= bus.byte_in;
        LEN_LO: if (accept) begin
          length[7:0] <= bus.byte_in;
          byte_cnt    <= '0;
          if ({1'b0, len_rx} > CAP) error <= 1'b1;
        end
        DATA: if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          shift    <= {shift[15:0], bus.byte_in};
          if (byte_cnt == 2'd3) begin
            bus.data_in    <= BUS_WIDTH'({shift, bus.byte_in});
            bus.write_addr <= word_count[ADDR_WIDTH-1:0];
            bus.wr_en      <= 1'b1;
            word_count     <= word_count + 1'b1;
          end
        end
        FLUSH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: logs memory writes and done pulses with
// their cycle numbers and compares them to hand-computed expectations.
module tb_instruction_loader;

  localparam int AW = 9;
  localparam int BW = 32;

  typedef logic [7:0] byte_q_t[$];

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy, done, error;
  logic [AW:0]   word_count;

  instruction_loader_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

  instruction_loader #(.CAPACITY(512), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [BW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            done_cyc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_addr_q.push_back(bus.write_addr);
      wr_data_q.push_back(bus.data_in);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) break;
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL byte_accept: byte %h not accepted within 20 cycles, wanted acceptance", b);
        bus.byte_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    last_acc       = cyc;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input byte_q_t s, input bit toggle);
    foreach (s[i]) begin
      send_byte(s[i]);
      if (toggle && i != s.size() - 1) idle(1);
    end
  endtask

  task automatic check_two_words(input string tag);
    checks++;
    if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL %s_nwrites: got %0d, wanted 2", tag, wr_addr_q.size());
    end else begin
      checks += 3;
      if (wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL %s_w0: got %0d/%h, wanted 0/deadbeef", tag, wr_addr_q[0], wr_data_q[0]);
      end
      if (wr_addr_q[1] !== 9'd1 || wr_data_q[1] !== 32'h12345678) begin
        errors++; $display("FAIL %s_w1: got %0d/%h, wanted 1/12345678", tag, wr_addr_q[1], wr_data_q[1]);
      end
      if (wr_cyc_q[1] !== last_acc) begin
        errors++; $display("FAIL %s_wr_latency: got cycle %0d, wanted %0d", tag, wr_cyc_q[1], last_acc);
      end
    end
    checks += 2;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_acc + 1) begin
      errors++; $display("FAIL %s_done: got %0d pulses, wanted 1 at cycle %0d", tag, done_cyc_q.size(), last_acc + 1);
    end
    if (word_count !== 10'd2 || error !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_status: got wc=%0d err=%b busy=%b, wanted 2/0/0", tag, word_count, error, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bus.byte_in = '0; bus.byte_valid = 1'b0;
    #12;
    checks++;
    if ({bus.byte_ready, bus.wr_en, busy, done, error, bus.write_addr, bus.data_in, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b busy=%b done=%b err=%b addr=%0d data=%h wc=%0d, wanted all 0",
               bus.byte_ready, bus.wr_en, busy, done, error, bus.write_addr, bus.data_in, word_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    clear_logs();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL basic_busy: got busy=%b err=%b, wanted 1/0", busy, error);
    end
    send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b0);
    idle(6);
    check_two_words("basic");
    if (wr_cyc_q.size() == 2) begin
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] !== 4) begin
        errors++; $display("FAIL basic_spacing: got %0d cycles, wanted 4", wr_cyc_q[1] - wr_cyc_q[0]);
      end
    end
  endtask

  task automatic test_toggle();
    clear_logs();
    pulse_start();
    checks++;
    if (word_count !== 10'd0) begin
      errors++; $display("FAIL toggle_wc_clear: got %0d, wanted 0", word_count);
    end
    send_stream('{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78}, 1'b1);
    idle(6);
    check_two_words("toggle");
  endtask

  task automatic test_zero_len();
    clear_logs();
    pulse_start();
    send_stream('{8'h00, 8'h00}, 1'b0);
    idle(4);
    checks += 2;
    if (wr_addr_q.size() !== 0 || word_count !== 10'd0) begin
      errors++; $display("FAIL zero_writes: got %0d writes wc=%0d, wanted 0/0", wr_addr_q.size(), word_count);
    end
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_acc + 1) begin
      errors++; $display("FAIL zero_done: got %0d pulses, wanted 1 at cycle %0d", done_cyc_q.size(), last_acc + 1);
    end
  endtask

  task automatic test_overflow();
    clear_logs();
    pulse_start();
    send_stream('{8'h02, 8'h01}, 1'b0);
    idle(4);
    checks += 2;
    if (error !== 1'b1 || wr_addr_q.size() !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_error: got err=%b writes=%0d busy=%b, wanted 1/0/0", error, wr_addr_q.size(), busy);
    end
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_acc + 1) begin
      errors++; $display("FAIL ovf_done: got %0d pulses, wanted 1 at cycle %0d", done_cyc_q.size(), last_acc + 1);
    end
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_clear: got err=%b busy=%b, wanted 0/1", error, busy);
    end
    send_stream('{8'h00, 8'h00}, 1'b0);
    idle(4);
  endtask

  task automatic test_full();
    byte_q_t s;
    int bad, zeros;
    clear_logs();
    s.push_back(8'h02); s.push_back(8'h00);
    for (int i = 0; i < 512; i++) begin
      logic [15:0] v;
      v = 16'(i);
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(v[15:8]); s.push_back(v[7:0]);
    end
    pulse_start();
    send_stream(s, 1'b0);
    idle(6);
    checks += 3;
    if (wr_addr_q.size() !== 512 || word_count !== 10'd512 || error !== 1'b0) begin
      errors++; $display("FAIL full_count: got %0d writes wc=%0d err=%b, wanted 512/512/0",
                         wr_addr_q.size(), word_count, error);
    end else begin
      bad = 0; zeros = 0;
      for (int i = 0; i < 512; i++) begin
        if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== BW'(i)) bad++;
        if (wr_addr_q[i] === '0) zeros++;
      end
      if (bad !== 0 || zeros !== 1) begin
        errors++; $display("FAIL full_contents: got %0d bad words, %0d writes to addr 0, wanted 0/1", bad, zeros);
      end
      if (wr_addr_q[511] !== 9'd511 || wr_data_q[511] !== 32'h000001FF) begin
        errors++; $display("FAIL full_last: got %0d/%h, wanted 511/000001ff", wr_addr_q[511], wr_data_q[511]);
      end
    end
    checks++;
    if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== last_acc + 1) begin
      errors++; $display("FAIL full_done: got %0d pulses, wanted 1 at cycle %0d", done_cyc_q.size(), last_acc + 1);
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'hAA, 8'hBB}, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.byte_ready, bus.wr_en, busy, done, error, bus.write_addr, bus.data_in, word_count} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b busy=%b addr=%0d data=%h wc=%0d, wanted all 0",
               bus.byte_ready, busy, bus.write_addr, bus.data_in, word_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    clear_logs();
    pulse_start();
    send_stream('{8'h00, 8'h01}, 1'b0);
    pulse_start();
    send_stream('{8'hCA, 8'hFE}, 1'b0);
    pulse_start();
    send_stream('{8'hBA, 8'hBE}, 1'b0);
    idle(1);
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL reload_done_now: got %b, wanted 1", done);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL start_on_done: got busy=%b, wanted 0", busy);
    end
    idle(3);
    checks += 2;
    if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 9'd0 || wr_data_q[0] !== 32'hCAFEBABE) begin
      errors++; $display("FAIL reload_write: got %0d writes, wanted 1 at addr 0 data cafebabe", wr_addr_q.size());
    end
    if (word_count !== 10'd1 || done_cyc_q.size() !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL reload_status: got wc=%0d dones=%0d busy=%b, wanted 1/1/0",
                         word_count, done_cyc_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero_len();
    test_overflow();
    test_full();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer-side companion to the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words from it.
- Drives the memory's write port (write_addr, data_in, wr_en) at sequential addresses starting from 0.
- Sits between the host/UART byte receiver and the instruction memory; used to boot-load programs before the core is released.

Parameters:
- CAPACITY, 512, number of instruction words in the target memory.
- BUS_WIDTH, 32, instruction word width in bits; fixed at 4 bytes.
- ADDR_WIDTH, $clog2(CAPACITY), write address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; ignored while busy=1.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- write_addr  output  ADDR_WIDTH  memory write address.
- data_in  output  BUS_WIDTH  memory write data.
- wr_en  output  1  memory write enable.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse at end of load (success or error).
- error  output  1  length exceeded CAPACITY.
- word_count  output  ADDR_WIDTH+1  words written in the current/last load.

Behaviour:
- Reset: all outputs are 0, state is IDLE, partial word is discarded. Reset mid-load aborts the load; words already written stay in memory.
- Handshake: a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1. byte_ready=1 only in LEN_HI, LEN_LO and DATA. byte_valid while not ready is held off by the source, never dropped by the loader.
- Stream format:
  - 16-bit word count N, big-endian (MSB byte first).
  - Then N words, each 4 bytes, MSB first.
- States:
  - IDLE: start=1 -> LEN_HI; busy=1 and error=0 from the next cycle; word_count cleared to 0.
  - LEN_HI: accept byte -> length[15:8]; -> LEN_LO.
  - LEN_LO: accept byte -> length[7:0].
    - N=0 -> FLUSH, no writes.
    - N>CAPACITY -> FLUSH, error=1, no writes.
    - Otherwise -> DATA.
  - DATA: 2-bit byte counter; bytes shift in MSB-first.
    - On the edge accepting the 4th byte: register data_in = assembled word, write_addr = word_count[ADDR_WIDTH-1:0], wr_en=1 for exactly one cycle; word_count increments on the same edge.
    - If this was word N -> FLUSH; else stay in DATA with the counter reset.
  - FLUSH: byte_ready=0. On the next edge: wr_en=0, done=1, busy=0, -> IDLE.
  - done deasserts one cycle later.
- Latency:
  - Last byte accepted at edge k -> wr_en high during cycle k..k+1 (memory captures at k+1).
  - done high during k+1..k+2.
  - Back-to-back bytes sustain one write per 4 cycles.
- wr_en is never asserted outside DATA->DATA/FLUSH transitions; write_addr and data_in hold their last values when wr_en=0.
- error stays set until the next accepted start.
- start coincident with done, or while busy, is ignored; start is honoured only in IDLE.
- word_count holds its final value after done.
- N=CAPACITY is legal; the last write is at address CAPACITY-1, with no wrap.

Test Plan:
- Reset then start; stream 00 02 DE AD BE EF 12 34 56 78 with byte_valid always 1 -> wr_en pulses at addr 0 data DEADBEEF and addr 1 data 12345678, 4 cycles apart; done pulses 1 cycle after the second wr_en; word_count=2; error=0.
- Same stream with byte_valid toggling every other cycle -> identical writes and data; no byte lost or duplicated.
- Length 00 00 -> no wr_en; done pulses 1 cycle after the second length byte; word_count=0.
- Length 02 01 (513 > 512) -> error=1, done pulse, no wr_en; error clears on the next start.
- Length 512 with data word = index -> last write at addr 511 data 000001FF; word_count=512; no write to addr 0 after the first.
- Assert rst_n=0 after 2 bytes of word 1 -> all outputs 0 immediately; a subsequent start reloads correctly from addr 0; extra start pulses during busy have no effect.
